// File: rtl/alu_ctrl_seq_pkg.sv
// Shared definitions for the ALU-control sequencer.
// Contents:
//   - 4-bit ALU control codes, including ALU_ILLEGAL (4'b1111)
//   - alu_op class constants
//   - func3 encodings for the B, R/I and M classes
//   - instruction kinds reported by the decoder
//   - sequencer FSM state encoding
package alu_ctrl_seq_pkg;

  localparam logic [3:0] ALU_ADD     = 4'h0;
  localparam logic [3:0] ALU_SUB     = 4'h1;
  localparam logic [3:0] ALU_SLL     = 4'h2;
  localparam logic [3:0] ALU_SLT     = 4'h3;
  localparam logic [3:0] ALU_SLTU    = 4'h4;
  localparam logic [3:0] ALU_XOR     = 4'h5;
  localparam logic [3:0] ALU_SRL     = 4'h6;
  localparam logic [3:0] ALU_SRA     = 4'h7;
  localparam logic [3:0] ALU_OR      = 4'h8;
  localparam logic [3:0] ALU_AND     = 4'h9;
  localparam logic [3:0] ALU_NOTEQ   = 4'hA;
  localparam logic [3:0] ALU_SGE     = 4'hB;
  localparam logic [3:0] ALU_SGEU    = 4'hC;
  localparam logic [3:0] ALU_JUMP    = 4'hD;
  localparam logic [3:0] ALU_MOPA    = 4'hE;
  localparam logic [3:0] ALU_ILLEGAL = 4'hF;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_B    = 3'b001;
  localparam logic [2:0] OP_R    = 3'b010;
  localparam logic [2:0] OP_I    = 3'b011;
  localparam logic [2:0] OP_JUMP = 3'b100;
  localparam logic [2:0] OP_M    = 3'b101;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_M_LD   = 3'b000;
  localparam logic [2:0] F3_M_ST   = 3'b001;
  localparam logic [2:0] F3_M_MVTR = 3'b010;
  localparam logic [2:0] F3_M_MVTM = 3'b011;
  localparam logic [2:0] F3_M_MOPA = 3'b100;

  localparam logic [1:0] KIND_SCALAR = 2'd0;
  localparam logic [1:0] KIND_MROW   = 2'd1;
  localparam logic [1:0] KIND_MOPA   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCALAR = 2'd1,
    ST_MROW   = 2'd2,
    ST_MOPA   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_ctrl_sequencer_decode.sv
// alu_ctrl_decode: purely combinational instruction-class decoder.
// Ports:
//   alu_op     in  3  instruction class
//   func3_code in  3  inst[14:12]
//   func7_code in  1  inst[30]
//   alu_ctrl   out 4  control code (ALU_ILLEGAL when unrecognised)
//   illegal    out 1  encoding unrecognised
//   kind       out 2  KIND_SCALAR / KIND_MROW / KIND_MOPA (illegal -> scalar)
module alu_ctrl_decode
  import alu_ctrl_seq_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [2:0] func3_code,
  input  logic       func7_code,
  output logic [3:0] alu_ctrl,
  output logic       illegal,
  output logic [1:0] kind
);

  always_comb begin
    alu_ctrl = ALU_ILLEGAL;
    kind     = KIND_SCALAR;
    case (alu_op)
      OP_ADD:  alu_ctrl = ALU_ADD;
      OP_JUMP: alu_ctrl = ALU_JUMP;
      OP_B: begin
        case (func3_code)
          F3_BEQ:  alu_ctrl = ALU_SUB;
          F3_BNE:  alu_ctrl = ALU_NOTEQ;
          F3_BLT:  alu_ctrl = ALU_SLT;
          F3_BGE:  alu_ctrl = ALU_SGE;
          F3_BLTU: alu_ctrl = ALU_SLTU;
          F3_BGEU: alu_ctrl = ALU_SGEU;
          default: alu_ctrl = ALU_ILLEGAL;
        endcase
      end
      OP_R: begin
        case ({func3_code, func7_code})
          {F3_ADD,  1'b0}: alu_ctrl = ALU_ADD;
          {F3_ADD,  1'b1}: alu_ctrl = ALU_SUB;
          {F3_SLL,  1'b0}: alu_ctrl = ALU_SLL;
          {F3_SLT,  1'b0}: alu_ctrl = ALU_SLT;
          {F3_SLTU, 1'b0}: alu_ctrl = ALU_SLTU;
          {F3_XOR,  1'b0}: alu_ctrl = ALU_XOR;
          {F3_SR,   1'b0}: alu_ctrl = ALU_SRL;
          {F3_SR,   1'b1}: alu_ctrl = ALU_SRA;
          {F3_OR,   1'b0}: alu_ctrl = ALU_OR;
          {F3_AND,  1'b0}: alu_ctrl = ALU_AND;
          default:         alu_ctrl = ALU_ILLEGAL;
        endcase
      end
      OP_I: begin
        // inst[30] is immediate data except for the shift encodings.
        case (func3_code)
          F3_ADD:  alu_ctrl = ALU_ADD;
          F3_SLL:  alu_ctrl = func7_code ? ALU_ILLEGAL : ALU_SLL;
          F3_SLT:  alu_ctrl = ALU_SLT;
          F3_SLTU: alu_ctrl = ALU_SLTU;
          F3_XOR:  alu_ctrl = ALU_XOR;
          F3_SR:   alu_ctrl = func7_code ? ALU_SRA : ALU_SRL;
          F3_OR:   alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      OP_M: begin
        case (func3_code)
          F3_M_LD, F3_M_ST, F3_M_MVTR, F3_M_MVTM: begin
            alu_ctrl = ALU_ADD;
            kind     = KIND_MROW;
          end
          F3_M_MOPA: begin
            alu_ctrl = ALU_MOPA;
            kind     = KIND_MOPA;
          end
          default: alu_ctrl = ALU_ILLEGAL;
        endcase
      end
      default: alu_ctrl = ALU_ILLEGAL;
    endcase
  end

  // No legal encoding maps to ALU_ILLEGAL, so the code itself flags it.
  assign illegal = (alu_ctrl == ALU_ILLEGAL);

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// alu_ctrl_sequencer: decodes ID/EX instructions into ALU control codes and
// expands matrix instructions into multi-beat micro-op streams.
// Optional build macro: ALU_CTRL_SEQ_PERF_EN adds perf_busy_cycles (32) and
// perf_mat_insns (16) saturating counters.
// Ports:
//   clk, rstn (async active-low), flush (synchronous abort)
//   in_valid/in_ready, alu_op, func3_code, func7_code : upstream side
//   out_valid/out_ready, alu_ctrl, row_idx, col_idx, sub_beat,
//   out_first, out_last, illegal                      : downstream side
//   fsm_state : current FSM state (state_e encoding) for observation
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and a presented beat holds every output
// stable until it transfers. in_ready may depend combinationally on out_ready
// so a new instruction can be taken on the cycle the final beat retires.
module alu_ctrl_sequencer
  import alu_ctrl_seq_pkg::*;
#(
  parameter int MAT_DIM   = 4,
  parameter int CTRL_W    = 4,
  parameter int IDX_W     = (MAT_DIM > 2) ? $clog2(MAT_DIM) : 1,
  parameter int ROW_BURST = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [2:0]        func3_code,
  input  logic              func7_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [IDX_W-1:0]  row_idx,
  output logic [IDX_W-1:0]  col_idx,
  output logic [1:0]        sub_beat,
  output logic              out_first,
  output logic              out_last,
`ifdef ALU_CTRL_SEQ_PERF_EN
  output logic [31:0]       perf_busy_cycles,
  output logic [15:0]       perf_mat_insns,
`endif
  output logic [1:0]        fsm_state,
  output logic              illegal
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_DIM - 1);
  localparam logic [1:0]       LAST_SUB = 2'(ROW_BURST - 1);

  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic [1:0] dec_kind;

  alu_ctrl_decode u_decode (
    .alu_op     (alu_op),
    .func3_code (func3_code),
    .func7_code (func7_code),
    .alu_ctrl   (dec_ctrl),
    .illegal    (dec_illegal),
    .kind       (dec_kind)
  );

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   row_q, row_d, col_q, col_d;
  logic [1:0]         sub_q, sub_d;
  logic [CTRL_W-1:0]  ctrl_q;
  logic               illegal_q;
  logic               last_beat, beat_fire, accept;

  always_comb begin
    last_beat = 1'b0;
    case (state_q)
      ST_SCALAR: last_beat = 1'b1;
      ST_MROW:   last_beat = (row_q == LAST_IDX) && (sub_q == LAST_SUB);
      ST_MOPA:   last_beat = (row_q == LAST_IDX) && (col_q == LAST_IDX);
      default:   last_beat = 1'b0;
    endcase
  end

  assign out_valid = (state_q != ST_IDLE);
  assign beat_fire = out_valid && out_ready;
  // Flush wins over acceptance, so refuse the instruction outright.
  assign in_ready  = !flush && ((state_q == ST_IDLE) || (beat_fire && last_beat));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    sub_d   = sub_q;
    if (flush) begin
      state_d = ST_IDLE;
      row_d   = '0;
      col_d   = '0;
      sub_d   = '0;
    end else begin
      if (beat_fire) begin
        if (last_beat) begin
          state_d = ST_IDLE;
          row_d   = '0;
          col_d   = '0;
          sub_d   = '0;
        end else begin
          case (state_q)
            ST_MROW: begin
              if (sub_q == LAST_SUB) begin
                sub_d = '0;
                row_d = row_q + IDX_W'(1);
              end else begin
                sub_d = sub_q + 2'd1;
              end
            end
            ST_MOPA: begin
              if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = row_q + IDX_W'(1);
              end else begin
                col_d = col_q + IDX_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
      // Counters are already zero here: acceptance only happens from IDLE
      // or alongside the final beat, both of which leave them cleared.
      if (accept) begin
        case (dec_kind)
          KIND_MROW: state_d = ST_MROW;
          KIND_MOPA: state_d = ST_MOPA;
          default:   state_d = ST_SCALAR;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      sub_q     <= '0;
      ctrl_q    <= '1;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sub_q   <= sub_d;
      if (accept && !flush) begin
        ctrl_q    <= dec_illegal ? '1 : CTRL_W'(dec_ctrl);
        illegal_q <= dec_illegal;
      end
    end
  end

  assign alu_ctrl  = ctrl_q;
  assign row_idx   = row_q;
  assign col_idx   = col_q;
  assign sub_beat  = sub_q;
  assign out_first = out_valid && (row_q == '0) && (col_q == '0) && (sub_q == '0);
  assign out_last  = out_valid && last_beat;
  assign illegal   = out_valid && illegal_q;
  assign fsm_state = state_q;

`ifdef ALU_CTRL_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy_cycles <= '0;
      perf_mat_insns   <= '0;
    end else begin
      if (out_valid && !out_ready && (perf_busy_cycles != '1))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (accept && (alu_op == OP_M) && (perf_mat_insns != '1))
        perf_mat_insns <= perf_mat_insns + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Testbench for alu_ctrl_sequencer (MAT_DIM=4, ROW_BURST=2).
// Driver tasks issue instructions; a monitor pushes the reference beats for
// every accepted instruction and pops/compares each retired beat.
module tb_alu_ctrl_sequencer;
  import alu_ctrl_seq_pkg::*;

  localparam int MAT_DIM   = 4;
  localparam int ROW_BURST = 2;
  localparam int IDX_W     = 2;

  typedef struct packed {
    logic [3:0]       ctrl;
    logic             ill;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [1:0]       sub;
    logic             first;
    logic             last;
  } beat_t;

  // Reference decode tables: B by func3, R and I by {func3,func7}, M by func3.
  localparam logic [3:0] B_MAP [8] = '{ALU_SUB, ALU_NOTEQ, ALU_ILLEGAL, ALU_ILLEGAL,
                                       ALU_SLT, ALU_SGE, ALU_SLTU, ALU_SGEU};
  localparam logic [3:0] R_MAP [16] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_ILLEGAL,
                                        ALU_SLT, ALU_ILLEGAL, ALU_SLTU, ALU_ILLEGAL,
                                        ALU_XOR, ALU_ILLEGAL, ALU_SRL, ALU_SRA,
                                        ALU_OR, ALU_ILLEGAL, ALU_AND, ALU_ILLEGAL};
  localparam logic [3:0] I_MAP [16] = '{ALU_ADD, ALU_ADD, ALU_SLL, ALU_ILLEGAL,
                                        ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU,
                                        ALU_XOR, ALU_XOR, ALU_SRL, ALU_SRA,
                                        ALU_OR, ALU_OR, ALU_AND, ALU_AND};
  localparam logic [3:0] M_MAP [8] = '{ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD,
                                       ALU_MOPA, ALU_ILLEGAL, ALU_ILLEGAL, ALU_ILLEGAL};

  logic             clk = 1'b0;
  logic             rstn, flush, in_valid, in_ready, func7_code;
  logic [2:0]       alu_op, func3_code;
  logic             out_valid, out_ready, out_first, out_last, illegal;
  logic [3:0]       alu_ctrl;
  logic [IDX_W-1:0] row_idx, col_idx;
  logic [1:0]       sub_beat, fsm_state;
`ifdef ALU_CTRL_SEQ_PERF_EN
  logic [31:0]      perf_busy_cycles;
  logic [15:0]      perf_mat_insns;
`endif

  alu_ctrl_sequencer #(.MAT_DIM(MAT_DIM), .CTRL_W(4), .IDX_W(IDX_W), .ROW_BURST(ROW_BURST)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func3_code(func3_code), .func7_code(func7_code),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .row_idx(row_idx), .col_idx(col_idx), .sub_beat(sub_beat),
    .out_first(out_first), .out_last(out_last),
`ifdef ALU_CTRL_SEQ_PERF_EN
    .perf_busy_cycles(perf_busy_cycles), .perf_mat_insns(perf_mat_insns),
`endif
    .fsm_state(fsm_state), .illegal(illegal)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  int    retired = 0;
  int    bubbles = 0;
  int    ready_mode = 0;  // 0: always ready, 1: toggle 1,0, 2: random
  beat_t exp_q[$];
  beat_t prev_beat;
  logic  prev_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // kind: 0 single beat, 1 row sweep, 2 full tile sweep
  function automatic void ref_decode(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                                     output logic [3:0] code, output int kind);
    logic [3:0] idx;
    idx  = {f3, f7};
    kind = 0;
    case (op)
      3'd0: code = ALU_ADD;
      3'd1: code = B_MAP[f3];
      3'd2: code = R_MAP[idx];
      3'd3: code = I_MAP[idx];
      3'd4: code = ALU_JUMP;
      3'd5: begin
        code = M_MAP[f3];
        if (f3 < 3'd4) kind = 1;
        else if (f3 == 3'd4) kind = 2;
      end
      default: code = ALU_ILLEGAL;
    endcase
  endfunction

  task automatic push_expected(input logic [2:0] op, input logic [2:0] f3, input logic f7);
    logic [3:0] code;
    int         kind, n, k;
    beat_t      b;
    ref_decode(op, f3, f7, code, kind);
    n = (kind == 0) ? 1 : (kind == 1) ? MAT_DIM * ROW_BURST : MAT_DIM * MAT_DIM;
    for (int i = 0; i < n; i++) begin
      b.ctrl  = code;
      b.ill   = (code == ALU_ILLEGAL);
      b.row   = '0;
      b.col   = '0;
      b.sub   = '0;
      if (kind == 1) begin
        k     = i / ROW_BURST;
        b.row = k[IDX_W-1:0];
        k     = i % ROW_BURST;
        b.sub = k[1:0];
      end else if (kind == 2) begin
        k     = i / MAT_DIM;
        b.row = k[IDX_W-1:0];
        k     = i % MAT_DIM;
        b.col = k[IDX_W-1:0];
      end
      b.first = (i == 0);
      b.last  = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic beat_t sample_beat();
    beat_t b;
    b.ctrl = alu_ctrl; b.ill = illegal; b.row = row_idx; b.col = col_idx;
    b.sub = sub_beat; b.first = out_first; b.last = out_last;
    return b;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    beat_t act, exp;
    act = sample_beat();
    if (!rstn) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (!out_valid || act !== prev_beat) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%b beat=%h expected valid=1 beat=%h",
                   out_valid, act, prev_beat);
        end
      end
      if (flush) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          n_cmp++;
          retired++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL beat_unexpected: got beat=%h expected no beat", act);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              n_err++;
              $display("FAIL beat: got ctrl=%h ill=%b row=%0d col=%0d sub=%0d first=%b last=%b expected ctrl=%h ill=%b row=%0d col=%0d sub=%0d first=%b last=%b",
                       act.ctrl, act.ill, act.row, act.col, act.sub, act.first, act.last,
                       exp.ctrl, exp.ill, exp.row, exp.col, exp.sub, exp.first, exp.last);
            end
          end
        end else if (!out_valid && exp_q.size() != 0) begin
          bubbles++;
        end
        prev_stall = out_valid && !out_ready;
        prev_beat  = act;
        if (in_valid && in_ready) push_expected(alu_op, func3_code, func7_code);
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] op, input logic [2:0] f3, input logic f7);
    bit acc = 0;
    in_valid = 1'b1; alu_op = op; func3_code = f3; func7_code = f7;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_retired(input int target);
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk); #1;
      if (retired >= target) done = 1;
    end
    if (!done) check("retire_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_alu_ctrl"},  32'(alu_ctrl),  32'hF);
    check({tag, "_row_idx"},   32'(row_idx),   32'd0);
    check({tag, "_col_idx"},   32'(col_idx),   32'd0);
    check({tag, "_sub_beat"},  32'(sub_beat),  32'd0);
    check({tag, "_first_last_ill"}, 32'({out_first, out_last, illegal}), 32'd0);
    check({tag, "_state"},     32'(fsm_state), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, bub0;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; func3_code = '0; func7_code = 1'b0;
    #12;
    check_reset_values("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // R-type SUB: single beat, in_ready stays high
    issue(OP_R, F3_ADD, 1'b1);
    @(negedge clk);
    check("sub_out_valid", 32'(out_valid), 32'd1);
    check("sub_in_ready", 32'(in_ready), 32'd1);
    drain();

    // MOPA followed by ADDI: 16 beats then ADDI without a bubble
    bub0 = bubbles;
    issue(OP_M, F3_M_MOPA, 1'b0);
    issue(OP_I, F3_ADD, 1'b0);
    drain();
    check("mopa_bubbles", 32'(bubbles - bub0), 32'd0);

    // M_LD with out_ready toggling: 8 beats retire
    ready_mode = 1;
    base = retired;
    issue(OP_M, F3_M_LD, 1'b0);
    drain();
    check("mld_beats", 32'(retired - base), 32'd8);
    ready_mode = 0;

    // Illegal encodings: SLLI with func7=1, B func3=010
    issue(OP_I, F3_SLL, 1'b1);
    issue(OP_B, 3'b010, 1'b0);
    drain();

    // Flush at MOPA beat 5 together with a new instruction
    base = retired;
    issue(OP_M, F3_M_MOPA, 1'b0);
    wait_retired(base + 5);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; alu_op = OP_I; func3_code = F3_ADD; func7_code = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_state", 32'(fsm_state), 32'(ST_IDLE));
    check("flush_idx", 32'({row_idx, col_idx, sub_beat}), 32'd0);
    @(negedge clk);
    check("flush_no_accept", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset during an MROW sequence, then a fresh MVTR
    base = retired;
    issue(OP_M, F3_M_MVTR, 1'b0);
    wait_retired(base + 2);
    #2 rstn = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    issue(OP_M, F3_M_MVTR, 1'b0);
    drain();

    // Randomised traffic with random downstream backpressure
    ready_mode = 2;
    for (int n = 0; n < 150; n++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) < 3) ? OP_M : 3'($urandom_range(0, 7));
      issue(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    ready_mode = 0;

    check("total_bubbles", 32'(bubbles), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
